// File: rtl/matmul_accum.sv
// Dot-product accumulator: sums tagged product terms over k, emits C[i][j] on the last term.
// Optional address-consistency check enabled by defining MATMUL_ACCUM_ADDRCHK_EN.
module matmul_accum #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_prod,
  input  logic [ADDR_W-1:0] in_addr_c,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_cnt,
  output logic              busy,
  output logic              err
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [ADDR_W-1:0] r_acc_addr;
  logic [ADDR_W-1:0] w_acc_addr_nxt;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_res_data;
  logic [ADDR_W-1:0] w_res_addr;
  logic              w_accept;
  logic              w_load;
  logic              w_out_hs;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_cnt;

  // A held result blocks every beat, last or not, so results leave in order.
  assign in_ready  = ~r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_out_hs  = r_out_valid & out_ready;
  assign w_sum     = r_acc + in_prod;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_cnt   = r_out_cnt;
  assign busy      = (r_state == ST_ACCUM) | r_out_valid;

  // Partial-sum state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_acc      <= {DATA_W{1'b0}};
      r_acc_addr <= {ADDR_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_acc_addr <= w_acc_addr_nxt;
    end
  end

  // Next partial sum and finished result; flush overrides any beat accepted the same cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_acc_addr_nxt = r_acc_addr;
    w_load         = 1'b0;
    w_res_data     = in_prod;
    w_res_addr     = in_addr_c;
    if (flush) begin
      w_state_nxt    = ST_EMPTY;
      w_acc_nxt      = {DATA_W{1'b0}};
      w_acc_addr_nxt = {ADDR_W{1'b0}};
    end else if (w_accept) begin
      case (r_state)
        ST_EMPTY: begin
          if (in_last) begin
            w_load      = 1'b1;
            w_res_data  = in_prod;
            w_res_addr  = in_addr_c;
            w_acc_nxt   = {DATA_W{1'b0}};
            w_state_nxt = ST_EMPTY;
          end else begin
            w_acc_nxt      = in_prod;
            w_acc_addr_nxt = in_addr_c;
            w_state_nxt    = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_last) begin
            w_load      = 1'b1;
            w_res_data  = w_sum;
            w_res_addr  = r_acc_addr;
            w_acc_nxt   = {DATA_W{1'b0}};
            w_state_nxt = ST_EMPTY;
          end else begin
            w_acc_nxt   = w_sum;
            w_state_nxt = ST_ACCUM;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_acc_nxt   = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // One-entry output register; a new result reloads it on the handshake edge without a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_addr  <= {ADDR_W{1'b0}};
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res_data;
      r_out_addr  <= w_res_addr;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // Delivered-result counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_cnt <= 32'd0;
    end else if (w_out_hs) begin
      r_out_cnt <= r_out_cnt + 32'd1;
    end
  end

`ifdef MATMUL_ACCUM_ADDRCHK_EN
  logic r_err;
  logic w_mismatch;

  assign w_mismatch = w_accept & (r_state == ST_ACCUM) & (in_addr_c != r_acc_addr);
  assign err        = r_err;

  // Sticky mismatch flag; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/matmul_accum.md
# matmul_accum

Reduction stage directly downstream of the matrix-multiply iteration datapath. It consumes the stream of per-iteration products A[i][k]·B[k][j], each tagged with its C[i][j] address, and sums them over the k loop. On the tagged last term it emits one finished C[i][j] word plus address to the memory write port. This replaces the per-iteration raw-product write with a true dot-product accumulate.

## Interface
Parameters:
- DATA_W, 32, product/accumulator width (unsigned, wraps mod 2^DATA_W)
- ADDR_W, 32, byte address width of C

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; discards the partial sum; does not touch the output register
- in_valid  in  1  product beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_prod  in  DATA_W  product term
- in_addr_c  in  ADDR_W  address of C[i][j] this term belongs to
- in_last  in  1  term is the final k of this dot product
- out_valid  out  1  finished result held
- out_ready  in  1  consumer takes result when out_valid & out_ready
- out_data  out  DATA_W  finished sum
- out_addr  out  ADDR_W  C address of out_data
- out_cnt  out  32  results delivered since reset (wraps)
- busy  out  1  partial sum held or out_valid high
- err  out  1  sticky address-mismatch flag (see Configuration)

## Operation
- Partial-sum FSM: EMPTY (no partial), ACCUM (acc/acc_addr valid). Reset and flush -> EMPTY, acc=0.
- Accepted beat in EMPTY, in_last=0: acc<=in_prod, acc_addr<=in_addr_c, -> ACCUM.
- Accepted beat in ACCUM, in_last=0: acc<=acc+in_prod (mod 2^DATA_W), stay ACCUM.
- Accepted beat with in_last=1: out_data<=(EMPTY ? in_prod : acc+in_prod), out_addr<=(EMPTY ? in_addr_c : acc_addr), out_valid<=1, acc<=0, -> EMPTY. Single-term dot product (k count 1) is legal.
- Output register is one entry. in_ready = ~out_valid | out_ready; non-last beats also obey this (simpler, keeps order).
- Output handshake: out_valid&out_ready clears out_valid unless a new last beat is accepted same edge, which reloads it (back-to-back, no bubble). out_cnt increments on every output handshake.
- flush with a simultaneous accepted beat: flush wins; beat is dropped, except the beat is still counted as accepted (in_ready unaffected). Pending output is kept.
- busy = (state==ACCUM) | out_valid.
- in_addr_c of non-first terms is otherwise ignored; result address is always the first term's address.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_addr=0, out_cnt=0, busy=0, err=0.
- Latency: last beat accepted at edge N -> out_valid=1 and out_data/out_addr stable from edge N to the handshake edge.
- Throughput: one beat per cycle while consumer holds out_ready=1.
- out_data/out_addr change only when out_valid loads; stable while out_valid&~out_ready.
- No combinational path in_valid -> in_ready; out_ready -> in_ready is combinational.
- Reset mid-sum: partial and pending output lost, FSM EMPTY next cycle after deassert.

## Configuration
- MATMUL_ACCUM_ADDRCHK_EN defined: in ACCUM, an accepted beat whose in_addr_c != acc_addr sets err (sticky until reset; flush does not clear). Accumulation continues unchanged.
- Undefined: no comparator; err tied to 0.

## Test plan
- 2x2·2x2 products streamed (k=2, last on every 2nd beat), out_ready=1: C words {19,22,43,50} at addresses base+{0,4,8,12}, out_cnt=4.
- Single-term beats 7,9 both in_last=1: out_data 7 then 9, no bubble between them.
- out_ready=0 with result pending, next last beat offered: in_ready=0, beat held; release out_ready -> both results in order, data stable while stalled.
- Sum 0xFFFF_FFFF + 2 -> out_data=1 (wrap).
- flush after one term (5) then term 3 last: out_data=3; reset asserted mid-sum -> all outputs at reset values.
- With MATMUL_ACCUM_ADDRCHK_EN: terms at addr 0x10 then 0x14 -> err=1, stays 1 after flush; without macro err=0.
